// File: rtl/qsys_regrw_pkg.sv
// rtl/qsys_regrw_pkg.sv - shared types and constants for the register R/W arbiter
//
// Purpose: arbiter FSM state encoding, requester port identifiers and the
// default read data returned when a slave transfer is aborted by the watchdog.

package qsys_regrw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way combinational round-robin grant
//
// Purpose: pick one of two requesters; on a tie the port that did not win
// last time is chosen.
// Ports:
//   req        in  2  request vector, bit 0 = port A, bit 1 = port B
//   lastGrant  in  1  port that completed the previous transfer
//   grant      out 1  winning port (valid only when gntValid)
//   gntValid   out 1  at least one request present

module rr_arb2
  import qsys_regrw_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastGrant,
  output logic       grant,
  output logic       gntValid
);

  always_comb begin
    gntValid = |req;
    grant    = PORT_A;
    if (req == 2'b11) begin
      grant = ~lastGrant;
    end else if (req[1]) begin
      grant = PORT_B;
    end
  end

endmodule

// File: rtl/qsys_regrw_arbiter.sv
// rtl/qsys_regrw_arbiter.sv - two-port Avalon-MM arbiter in front of one register slave
//
// Purpose: round-robin arbitration between the MCU bridge (port A) and the
// internal sequencer (port B) for a single register slave. The winning command
// is registered onto the master port; the completion (waitrequest low for one
// cycle plus read data) goes back to the owning port only. A watchdog aborts
// a transfer the slave never finishes and raises a sticky error.
// Ports:
//   csi_MCLK_clk        in   1       clock
//   rsi_MRST_reset_n    in   1       synchronous active-low reset
//   avs_PA_*            slave port A (address/read/write/writedata in,
//                                     readdata/waitrequest out)
//   avs_PB_*            slave port B, same signals as port A
//   avm_M_*             master port to the register slave
//   coe_TIMEOUT_err     out  1       sticky watchdog abort flag

module qsys_regrw_arbiter
  import qsys_regrw_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 4,
  parameter int                TIMEOUT_CYC  = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(DEFAULT_TIMEOUT_DATA)
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset_n,

  input  logic [ADDR_W-1:0] avs_PA_address,
  input  logic              avs_PA_read,
  input  logic              avs_PA_write,
  input  logic [DATA_W-1:0] avs_PA_writedata,
  output logic [DATA_W-1:0] avs_PA_readdata,
  output logic              avs_PA_waitrequest,

  input  logic [ADDR_W-1:0] avs_PB_address,
  input  logic              avs_PB_read,
  input  logic              avs_PB_write,
  input  logic [DATA_W-1:0] avs_PB_writedata,
  output logic [DATA_W-1:0] avs_PB_readdata,
  output logic              avs_PB_waitrequest,

  output logic [ADDR_W-1:0] avm_M_address,
  output logic              avm_M_read,
  output logic              avm_M_write,
  output logic [DATA_W-1:0] avm_M_writedata,
  input  logic [DATA_W-1:0] avm_M_readdata,
  input  logic              avm_M_waitrequest,

  output logic              coe_TIMEOUT_err
);

  // Counter only has to reach TIMEOUT_CYC-1.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  stateT             state;
  stateT             nextState;
  logic              owner;
  logic              lastGrant;
  logic              grant;
  logic              gntValid;
  logic              reqA;
  logic              reqB;
  logic              loadCmd;
  logic              finishCmd;
  logic              abortCmd;
  logic              timeoutHit;
  logic [CNT_W-1:0]  toCount;
  logic [DATA_W-1:0] captureData;

  assign reqA = avs_PA_read | avs_PA_write;
  assign reqB = avs_PB_read | avs_PB_write;

  // Only the owner is released, and only in DONE; reset stalls everyone.
  assign avs_PA_waitrequest = !rsi_MRST_reset_n ||
                              (reqA && !(state == DONE && owner == PORT_A));
  assign avs_PB_waitrequest = !rsi_MRST_reset_n ||
                              (reqB && !(state == DONE && owner == PORT_B));

  assign timeoutHit  = (TIMEOUT_CYC != 0) && (toCount == TO_LAST);
  assign captureData = abortCmd ? TIMEOUT_DATA : avm_M_readdata;

  rr_arb2 uArb (
    .req      ({reqB, reqA}),
    .lastGrant(lastGrant),
    .grant    (grant),
    .gntValid (gntValid)
  );

  always_comb begin
    nextState = state;
    loadCmd   = 1'b0;
    finishCmd = 1'b0;
    abortCmd  = 1'b0;
    case (state)
      IDLE: begin
        if (gntValid) begin
          loadCmd   = 1'b1;
          nextState = BUSY;
        end
      end
      BUSY: begin
        if (!avm_M_waitrequest) begin
          finishCmd = 1'b1;
          nextState = DONE;
        end else if (timeoutHit) begin
          abortCmd  = 1'b1;
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      state           <= IDLE;
      owner           <= PORT_A;
      lastGrant       <= PORT_B;
      avm_M_read      <= 1'b0;
      avm_M_write     <= 1'b0;
      avm_M_address   <= '0;
      avm_M_writedata <= '0;
      toCount         <= '0;
      coe_TIMEOUT_err <= 1'b0;
      avs_PA_readdata <= '0;
      avs_PB_readdata <= '0;
    end else begin
      state <= nextState;

      // read&write together is a write, so read is only the non-write case.
      if (loadCmd) begin
        owner   <= grant;
        toCount <= '0;
        if (grant == PORT_B) begin
          avm_M_address   <= avs_PB_address;
          avm_M_writedata <= avs_PB_writedata;
          avm_M_write     <= avs_PB_write;
          avm_M_read      <= !avs_PB_write;
        end else begin
          avm_M_address   <= avs_PA_address;
          avm_M_writedata <= avs_PA_writedata;
          avm_M_write     <= avs_PA_write;
          avm_M_read      <= !avs_PA_write;
        end
      end

      // Result lands directly in the owner's readdata so it is valid in DONE
      // and held until that port's next completion.
      if (finishCmd || abortCmd) begin
        avm_M_read  <= 1'b0;
        avm_M_write <= 1'b0;
        if (owner == PORT_B) begin
          avs_PB_readdata <= captureData;
        end else begin
          avs_PA_readdata <= captureData;
        end
      end

      if (abortCmd) begin
        coe_TIMEOUT_err <= 1'b1;
      end

      if (state == BUSY && avm_M_waitrequest && !timeoutHit) begin
        toCount <= toCount + CNT_W'(1);
      end

      if (state == DONE) begin
        lastGrant <= owner;
        toCount   <= '0;
      end
    end
  end

endmodule
